// File: rtl/prog_freqdiv.sv
// prog_freqdiv: runtime-programmable divider / tick generator.
// Period and high time are reloaded through a load/ack handshake and only
// change at period boundaries (or while stopped), so a running output never
// sees a truncated or stretched period. Supports continuous and one-shot runs.
module prog_freqdiv #(
  parameter int unsigned WIDTH    = 27,
  parameter int unsigned DEF_DIV  = 99999999,
  parameter int unsigned DEF_HIGH = 50000000
) (
  input  logic             clk100M,
  input  logic             clr,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] sh_div_q, sh_div_d;
  logic [WIDTH-1:0] sh_high_q, sh_high_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             load_ack_q, load_ack_d;

  logic running;
  logic boundary;
  logic apply_pt;
  logic run_next;

  // Settings path: shadow capture, pending flag and application at safe points
  always_comb begin
    sh_div_d   = sh_div_q;
    sh_high_d  = sh_high_q;
    div_d      = div_q;
    high_d     = high_q;
    pending_d  = pending_q;
    load_ack_d = load;

    // A completed one-shot stays parked until en drops.
    running  = en && (state_q != ST_DONE);
    boundary = (state_q == ST_RUN) && (count_q == div_q);
    // New settings may land wherever the next cycle begins a fresh period
    // or the divider is stopped.
    apply_pt = !running || (state_q != ST_RUN) || boundary;

    if (load) begin
      sh_div_d  = div_in;
      sh_high_d = high_in;
    end

    if (apply_pt) begin
      if (load) begin
        div_d  = div_in;
        high_d = high_in;
      end else if (pending_q) begin
        div_d  = sh_div_q;
        high_d = sh_high_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Run-state FSM, period counter and next-state output decode
  always_comb begin
    state_d = state_q;
    count_d = '0;

    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (boundary) begin
            if (mode) state_d = ST_DONE;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        default: state_d = ST_DONE;
      endcase
    end

    // Outputs are registered from next-state values so they line up with count.
    run_next  = (state_d == ST_RUN);
    tick_d    = run_next && (count_d == '0);
    clk_out_d = run_next && (count_d < high_d);
  end

  // State registers with synchronous clear restoring defaults
  always_ff @(posedge clk100M) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      div_q      <= WIDTH'(DEF_DIV);
      high_q     <= WIDTH'(DEF_HIGH);
      sh_div_q   <= '0;
      sh_high_q  <= '0;
      pending_q  <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      div_q      <= div_d;
      high_q     <= high_d;
      sh_div_q   <= sh_div_d;
      sh_high_q  <= sh_high_d;
      pending_q  <= pending_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      load_ack_q <= load_ack_d;
    end
  end

  assign load_ack = load_ack_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign count    = count_q;

endmodule
